// File: rtl/scan_sipo_decrypt_piso.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : scan_sipo_decrypt_piso                                         |
// | Purpose  : Scan-port receive path. Deserializes a ciphertext block, hands |
// |            it to an external inverse-cipher core and serializes the      |
// |            plaintext back out. Optional macro DEC_TIMEOUT_EN adds a core |
// |            response watchdog with a sticky err_timeout flag.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module scan_sipo_decrypt_piso #(
    parameter int BLOCK_W     = 128,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               start,
    input  logic               serial_in,
    input  logic [KEY_W-1:0]   initial_key,
    output logic               dec_start,
    output logic [BLOCK_W-1:0] dec_data_in,
    output logic [KEY_W-1:0]   dec_key,
    input  logic [BLOCK_W-1:0] dec_data_out,
    input  logic               dec_done,
    output logic               serial_out,
    output logic               out_valid,
    output logic               busy,
    output logic               block_done,
    output logic               err_timeout
);

    localparam int                 c_cnt_w    = $clog2(BLOCK_W) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(BLOCK_W);

    if (BLOCK_W < 2 || KEY_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("scan_sipo_decrypt_piso: invalid parameter values");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_DEC_REQ   = 3'd2,
        S_DEC_WAIT  = 3'd3,
        S_SHIFT_OUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] sreg_q, sreg_d;
    logic [BLOCK_W-1:0] oreg_q, oreg_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               block_done_q, block_done_d;

    logic               w_accept;
    logic               w_tmo_hit;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign w_accept  = (state_q == S_IDLE) && en && start;
    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        oreg_d       = oreg_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        block_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    key_d   = initial_key;
                    cnt_d   = '0;
                    state_d = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                if (en) begin
                    sreg_d = {sreg_q[BLOCK_W-2:0], serial_in};
                    cnt_d  = w_cnt_inc;
                    if (w_cnt_inc == c_cnt_full) begin
                        state_d = S_DEC_REQ;
                    end
                end
            end
            S_DEC_REQ: begin
                state_d = S_DEC_WAIT;
            end
            S_DEC_WAIT: begin
                // A response on the expiry edge still wins over the timeout.
                if (dec_done) begin
                    oreg_d  = dec_data_out;
                    cnt_d   = '0;
                    state_d = S_SHIFT_OUT;
                end else if (w_tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT_OUT: begin
                if (en) begin
                    oreg_d = {oreg_q[BLOCK_W-2:0], 1'b0};
                    cnt_d  = w_cnt_inc;
                    if (w_cnt_inc == c_cnt_full) begin
                        block_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sreg_q       <= '0;
            oreg_q       <= '0;
            key_q        <= '0;
            cnt_q        <= '0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            oreg_q       <= oreg_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            block_done_q <= block_done_d;
        end
    end

`ifdef DEC_TIMEOUT_EN
    localparam int                 c_tmo_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT_CYC);

    logic [c_tmo_w-1:0] tmo_q, tmo_d;
    logic               err_q, err_d;

    // tmo_q holds the number of cycles elapsed since the dec_start cycle.
    assign w_tmo_hit = (state_q == S_DEC_WAIT) && !dec_done && (tmo_q == c_tmo_lim);

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (w_accept) begin
            err_d = 1'b0;
        end
        if (state_q == S_DEC_REQ) begin
            tmo_d = c_tmo_w'(1);
        end else if ((state_q == S_DEC_WAIT) && !dec_done && (tmo_q != c_tmo_lim)) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (w_tmo_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign w_tmo_hit   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign dec_start   = (state_q == S_DEC_REQ);
    assign dec_data_in = sreg_q;
    assign dec_key     = key_q;
    assign out_valid   = (state_q == S_SHIFT_OUT);
    assign serial_out  = (state_q == S_SHIFT_OUT) && oreg_q[BLOCK_W-1];
    assign busy        = (state_q != S_IDLE);
    assign block_done  = block_done_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sipo_decrypt_piso.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_scan_sipo_decrypt_piso                                      |
// | Purpose  : Bench for scan_sipo_decrypt_piso with a behavioural core stub; |
// |            DEC_TIMEOUT_EN selects the watchdog scenario.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_scan_sipo_decrypt_piso;

    localparam int BW  = 128;
    localparam int TMO = 64;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          start;
    logic          serial_in;
    logic [BW-1:0] initial_key;
    logic          dec_start;
    logic [BW-1:0] dec_data_in;
    logic [BW-1:0] dec_key;
    logic [BW-1:0] dec_data_out;
    logic          dec_done;
    logic          serial_out;
    logic          out_valid;
    logic          busy;
    logic          block_done;
    logic          err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    scan_sipo_decrypt_piso #(
        .BLOCK_W     (BW),
        .KEY_W       (BW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .start        (start),
        .serial_in    (serial_in),
        .initial_key  (initial_key),
        .dec_start    (dec_start),
        .dec_data_in  (dec_data_in),
        .dec_key      (dec_key),
        .dec_data_out (dec_data_out),
        .dec_done     (dec_done),
        .serial_out   (serial_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .block_done   (block_done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Core model: the real FIPS-197 vector for C.1, an invertible mix otherwise.
    function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] c, input logic [BW-1:0] k);
        if (c == C1_CT && k == C1_KEY) return C1_PT;
        return c ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [BW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core stub: answers dec_start after a latency, optionally spurious pulses.
    bit            core_mute   = 1'b0;
    bit            spurious_en = 1'b0;
    int            lat_force   = 0;
    logic [BW-1:0] job_ct  = '0;
    logic [BW-1:0] job_key = '0;

    initial begin
        bit pending;
        int wait_left;
        pending      = 1'b0;
        wait_left    = 0;
        dec_done     = 1'b0;
        dec_data_out = '0;
        forever begin
            @(negedge clk);
            dec_done = 1'b0;
            if (!reset_n) begin
                pending = 1'b0;
            end else if (pending) begin
                wait_left--;
                if (wait_left == 0) begin
                    dec_done     = 1'b1;
                    dec_data_out = core_fn(job_ct, job_key);
                    pending      = 1'b0;
                end
            end else if (dec_start) begin
                job_ct  = dec_data_in;
                job_key = dec_key;
                if (!core_mute) begin
                    pending   = 1'b1;
                    wait_left = (lat_force > 0) ? lat_force : int'($urandom_range(1, 8));
                end
            end else if (spurious_en && !core_mute && $urandom_range(0, 9) == 0) begin
                dec_done     = 1'b1;
                dec_data_out = rand128();
            end
        end
    end

    int n_bd = 0, n_ds = 0, n_ov = 0, n_err = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (block_done === 1'b1)  n_bd++;
            if (dec_start === 1'b1)   n_ds++;
            if (out_valid === 1'b1)   n_ov++;
            if (err_timeout === 1'b1) n_err++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver results, read by the scenario tasks.
    logic [BW-1:0] r_pt;
    int            r_nbits, r_stall_bad, r_busy_low, r_ov_early, r_wait_cycles;
    logic          r_busy_after_accept, r_err_after_accept, r_final_busy, r_final_bd, r_tmo;

    // Runs one block from an IDLE negedge; returns at the negedge after the last shift.
    task automatic drive_block(input logic [BW-1:0] ct, input logic [BW-1:0] key,
                               input int stall_every, input bit key_change,
                               input bit keep_start, input bit stop_on_tmo);
        int   idx, cyc, guard;
        bit   en_now, prev_stall;
        logic prev_bit;
        r_pt = '0; r_nbits = 0; r_stall_bad = 0; r_busy_low = 0;
        r_ov_early = 0; r_wait_cycles = 0; r_tmo = 1'b0;
        initial_key = key;
        start       = 1'b1;
        en          = 1'b1;
        @(negedge clk);
        r_busy_after_accept = busy;
        r_err_after_accept  = err_timeout;
        if (!keep_start) start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < BW && cyc < 1000) begin
            en_now    = !(stall_every > 0 && (cyc % stall_every) == stall_every - 1);
            en        = en_now;
            serial_in = en_now ? ct[BW-1-idx] : 1'($urandom_range(0, 1));
            if (en_now) idx++;
            if (key_change && idx == 40) initial_key = '1;
            cyc++;
            @(negedge clk);
            if (!busy)    r_busy_low++;
            if (out_valid) r_ov_early++;
        end
        guard = 0;
        while (!out_valid && guard < 300) begin
            if (stop_on_tmo && err_timeout) break;
            if (!busy) r_busy_low++;
            en = 1'($urandom_range(0, 1));
            guard++;
            r_wait_cycles++;
            @(negedge clk);
        end
        en = 1'b1;
        if (stop_on_tmo) begin
            r_tmo        = err_timeout;
            r_final_busy = busy;
            r_final_bd   = block_done;
            return;
        end
        cyc = 0; guard = 0; prev_stall = 1'b0; prev_bit = 1'b0;
        while (out_valid && guard < 600) begin
            if (prev_stall && serial_out !== prev_bit) r_stall_bad++;
            en_now = !(stall_every > 0 && (cyc % stall_every) == stall_every - 1);
            en     = en_now;
            if (en_now) begin
                r_pt = {r_pt[BW-2:0], serial_out};
                r_nbits++;
            end
            prev_stall = !en_now;
            prev_bit   = serial_out;
            cyc++;
            guard++;
            @(negedge clk);
            if (!busy && out_valid) r_busy_low++;
        end
        en           = 1'b1;
        r_final_busy = busy;
        r_final_bd   = block_done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; start = 1'b0; serial_in = 1'b0; initial_key = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, out_valid, serial_out, dec_start, block_done, err_timeout} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, out_valid, serial_out, dec_start, block_done, err_timeout});
        end
        n_checks++;
        if (dec_data_in !== '0 || dec_key !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got data %h key %h expected zero", dec_data_in, dec_key);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_fips_c1();
        int bd0 = n_bd, ds0 = n_ds;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (r_pt !== C1_PT) begin
            n_errors++; $display("FAIL c1_plaintext: got %h expected %h", r_pt, C1_PT);
        end
        n_checks++;
        if (r_nbits != BW) begin
            n_errors++; $display("FAIL c1_nbits: got %0d expected %0d", r_nbits, BW);
        end
        n_checks++;
        if (job_ct !== C1_CT || job_key !== C1_KEY) begin
            n_errors++; $display("FAIL c1_core_inputs: got ct %h key %h expected %h %h", job_ct, job_key, C1_CT, C1_KEY);
        end
        n_checks++;
        if (n_bd - bd0 != 1 || n_ds - ds0 != 1) begin
            n_errors++; $display("FAIL c1_pulses: got block_done %0d dec_start %0d expected 1 1", n_bd - bd0, n_ds - ds0);
        end
        n_checks++;
        if (r_final_bd !== 1'b1 || r_final_busy !== 1'b0 || r_busy_low != 0 || r_ov_early != 0) begin
            n_errors++; $display("FAIL c1_handshake: got bd %b busy %b busy_low %0d early_valid %0d expected 1 0 0 0",
                                 r_final_bd, r_final_busy, r_busy_low, r_ov_early);
        end
    endtask

    task automatic test_stall();
        int bd0 = n_bd;
        spurious_en = 1'b1;
        drive_block(C1_CT, C1_KEY, 3, 1'b0, 1'b0, 1'b0);
        spurious_en = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (r_pt !== C1_PT || r_nbits != BW) begin
            n_errors++; $display("FAIL stall_plaintext: got %h (%0d bits) expected %h (128 bits)", r_pt, r_nbits, C1_PT);
        end
        n_checks++;
        if (r_stall_bad != 0) begin
            n_errors++; $display("FAIL stall_hold: got %0d changed bits during stalls expected 0", r_stall_bad);
        end
        n_checks++;
        if (n_bd - bd0 != 1) begin
            n_errors++; $display("FAIL stall_block_done: got %0d expected 1", n_bd - bd0);
        end
    endtask

    task automatic test_back_to_back();
        int            bd0 = n_bd, ds0 = n_ds;
        logic [BW-1:0] pt1;
        logic          busy_gap;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b1, 1'b0);
        pt1      = r_pt;
        busy_gap = r_final_busy;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (pt1 !== C1_PT || r_pt !== C1_PT) begin
            n_errors++; $display("FAIL b2b_plaintext: got %h and %h expected %h", pt1, r_pt, C1_PT);
        end
        n_checks++;
        if (busy_gap !== 1'b0 || r_busy_after_accept !== 1'b1) begin
            n_errors++; $display("FAIL b2b_idle_gap: got busy %b then %b expected 0 then 1", busy_gap, r_busy_after_accept);
        end
        n_checks++;
        if (n_bd - bd0 != 2 || n_ds - ds0 != 2) begin
            n_errors++; $display("FAIL b2b_pulses: got block_done %0d dec_start %0d expected 2 2", n_bd - bd0, n_ds - ds0);
        end
    endtask

    task automatic test_reset_mid();
        int bd0, ds0;
        initial_key = C1_KEY; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            serial_in = C1_CT[BW-1-i];
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        bd0 = n_bd; ds0 = n_ds;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, out_valid, serial_out, dec_start, block_done} !== 5'b0 || dec_data_in !== '0 || dec_key !== '0) begin
            n_errors++; $display("FAIL midrst_async: got flags %b data %h key %h expected all zero",
                                 {busy, out_valid, serial_out, dec_start, block_done}, dec_data_in, dec_key);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (r_pt !== C1_PT || n_bd - bd0 != 1 || n_ds - ds0 != 1) begin
            n_errors++; $display("FAIL midrst_fresh_block: got %h bd %0d ds %0d expected %h 1 1",
                                 r_pt, n_bd - bd0, n_ds - ds0, C1_PT);
        end
    endtask

    task automatic test_key_change();
        drive_block(C1_CT, C1_KEY, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (job_key !== C1_KEY) begin
            n_errors++; $display("FAIL keychg_dec_key: got %h expected %h", job_key, C1_KEY);
        end
        n_checks++;
        if (r_pt !== C1_PT) begin
            n_errors++; $display("FAIL keychg_plaintext: got %h expected %h", r_pt, C1_PT);
        end
    endtask

    task automatic test_random_blocks();
        logic [BW-1:0] ct, key, exp_pt;
        int            st;
        spurious_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            ct  = rand128();
            key = rand128();
            st  = $urandom_range(1, 4);
            if (st == 1) st = 0;
            exp_pt = core_fn(ct, key);
            drive_block(ct, key, st, 1'b0, 1'b0, 1'b0);
            @(negedge clk); #1;
            n_checks++;
            if (r_pt !== exp_pt || r_nbits != BW || job_ct !== ct || job_key !== key) begin
                n_errors++; $display("FAIL random_block%0d: got pt %h ct %h (%0d bits) expected pt %h ct %h",
                                     b, r_pt, job_ct, r_nbits, exp_pt, ct);
            end
        end
        spurious_en = 1'b0;
    endtask

`ifdef DEC_TIMEOUT_EN
    task automatic test_dec_wait();
        int ov0, bd0;
        lat_force = TMO;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b0);
        lat_force = 0;
        @(negedge clk); #1;
        n_checks++;
        if (r_pt !== C1_PT || err_timeout !== 1'b0) begin
            n_errors++; $display("FAIL tmo_limit_done: got %h err %b expected %h err 0", r_pt, err_timeout, C1_PT);
        end
        core_mute = 1'b1;
        ov0 = n_ov; bd0 = n_bd;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b1);
        // Last accepted response is in cycle TMO after dec_start; flag shows one cycle later.
        n_checks++;
        if (r_tmo !== 1'b1 || r_wait_cycles != TMO + 1 || r_final_busy !== 1'b0) begin
            n_errors++; $display("FAIL tmo_fire: got err %b after %0d cycles busy %b expected 1 after %0d busy 0",
                                 r_tmo, r_wait_cycles, r_final_busy, TMO + 1);
        end
        core_mute = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (err_timeout !== 1'b1 || n_ov != ov0 || n_bd != bd0) begin
            n_errors++; $display("FAIL tmo_sticky: got err %b out_valid %0d block_done %0d expected 1 0 0",
                                 err_timeout, n_ov - ov0, n_bd - bd0);
        end
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (r_err_after_accept !== 1'b0 || r_pt !== C1_PT) begin
            n_errors++; $display("FAIL tmo_clear: got err %b pt %h expected 0 %h", r_err_after_accept, r_pt, C1_PT);
        end
    endtask
`else
    task automatic test_dec_wait();
        lat_force = 150;
        drive_block(C1_CT, C1_KEY, 0, 1'b0, 1'b0, 1'b0);
        lat_force = 0;
        @(negedge clk); #1;
        n_checks++;
        if (r_pt !== C1_PT || r_nbits != BW) begin
            n_errors++; $display("FAIL slow_core: got %h (%0d bits) expected %h", r_pt, r_nbits, C1_PT);
        end
        n_checks++;
        if (n_err != 0) begin
            n_errors++; $display("FAIL no_timeout_flag: got %0d cycles of err_timeout expected 0", n_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips_c1();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_key_change();
        test_random_blocks();
        test_dec_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
